// File: rtl/lc3_fetch.sv
// lc3_fetch: instruction fetch stage for the LC-3 core.
//
// Issues single-word reads to instruction memory (req/gnt, then rvalid) with
// at most one read outstanding, buffers {pc, word} pairs in a small prefetch
// FIFO, and hands the FIFO head to the CPU over valid/ready. It supports
// branch redirect (flush + refetch) and a sticky halt.
//
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   o_mem_req/o_mem_addr         read request and address (= fetch PC)
//   i_mem_gnt                    request accepted this cycle
//   i_mem_rvalid/i_mem_rdata     read response
//   o_instr_valid/o_instr/o_instr_pc  FIFO head to the CPU
//   i_instr_ready                CPU pops the head
//   i_redirect/i_redirect_pc     taken branch: flush and refetch
//   i_halt                       stop issuing fetches until reset

// One prefetch FIFO slot: PC and instruction word, written on i_we.
module lc3_fetch_slot #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_data
);
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc   <= '0;
      r_data <= '0;
    end else if (i_we) begin
      r_pc   <= i_pc;
      r_data <= i_data;
    end
  end

  assign o_pc   = r_pc;
  assign o_data = r_data;
endmodule

module lc3_fetch #(
  parameter int              ADDR_W     = 16,
  parameter int              DATA_W     = 16,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_instr_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  input  logic              i_instr_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_halt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_halt;
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_halt;
  logic              w_gnt;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_nxt;

  logic [FIFO_DEPTH-1:0]             w_slot_we;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] w_slot_pc;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] w_slot_data;

  // Halt takes effect in the cycle it is first seen, then stays latched.
  assign w_halt = r_halt | i_halt;
  assign w_gnt  = (r_state == S_REQ) & i_mem_gnt;
  // A redirect discards both the returning word and any pop in that cycle.
  assign w_push = (r_state == S_WAIT) & i_mem_rvalid & ~i_redirect;
  assign w_pop  = (r_count != '0) & i_instr_ready & ~i_redirect;
  // Occupancy after this cycle's push/pop; decides whether WAIT may refetch.
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        // A redirect empties the FIFO, so there is room by construction.
        if (w_halt)                               w_state_nxt = S_HALTED;
        else if (i_redirect || r_count < DEPTH_C) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (i_redirect)     w_state_nxt = i_mem_gnt ? S_DRAIN : S_REQ;
        else if (i_mem_gnt) w_state_nxt = S_WAIT;
        else if (w_halt)    w_state_nxt = S_HALTED;
      end
      S_WAIT: begin
        if (i_redirect) begin
          // Stale response: drop it now, or drain it later if not yet back.
          if (i_mem_rvalid) w_state_nxt = w_halt ? S_HALTED : S_REQ;
          else              w_state_nxt = S_DRAIN;
        end else if (i_mem_rvalid) begin
          if (w_halt)                     w_state_nxt = S_HALTED;
          else if (w_count_nxt < DEPTH_C) w_state_nxt = S_REQ;
          else                            w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (i_mem_rvalid) w_state_nxt = S_IDLE;
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_mem_req = (r_state == S_REQ);
  end

  assign o_mem_addr = r_fetch_pc;

  // ---------------- fetch PC / halt ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_halt     <= 1'b0;
    end else begin
      if (i_halt) r_halt <= 1'b1;
      if (w_gnt) r_req_pc <= r_fetch_pc;
      // Redirect wins over the post-grant increment (granted fetch is stale).
      if (i_redirect) r_fetch_pc <= i_redirect_pc;
      else if (w_gnt) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
    end
  end

  // ---------------- FIFO pointers ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // ---------------- FIFO storage ----------------
  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_slot
    assign w_slot_we[g] = w_push && (r_wr_ptr == PTR_W'(g));

    lc3_fetch_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_we   (w_slot_we[g]),
      .i_pc   (r_req_pc),
      .i_data (i_mem_rdata),
      .o_pc   (w_slot_pc[g]),
      .o_data (w_slot_data[g])
    );
  end

  // Head comes straight from slot registers, so it holds while stalled.
  assign o_instr_valid = (r_count != '0);
  assign o_instr       = w_slot_data[r_rd_ptr];
  assign o_instr_pc    = w_slot_pc[r_rd_ptr];
endmodule

// File: tb/tb_lc3_fetch.sv
// Directed bench for lc3_fetch with a zero-wait memory model
// (gnt = req & gnt_en, rvalid one cycle after grant, mem[a] = a + 16'h1000).
module tb_lc3_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        m_rv = 1'b0;
  logic [15:0] m_rd = 16'h0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        gnt_en;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  lc3_fetch #(
    .ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(4), .RESET_PC(16'h0000)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_gnt     (mem_gnt),
    .i_mem_rvalid  (m_rv),
    .i_mem_rdata   (m_rd),
    .o_instr_valid (instr_valid),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .i_instr_ready (ready),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_halt        (halt)
  );

  assign mem_gnt = mem_req & gnt_en;

  always @(posedge clk) begin
    m_rv <= mem_req & mem_gnt;
    if (mem_req & mem_gnt) m_rd <= mem_addr + 16'h1000;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves rst low #1 after a rising edge; the next edge is "edge1".
  task automatic do_reset(input logic rdy, input logic gen);
    rst = 1'b1; ready = rdy; gnt_en = gen;
    redirect = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ready = 1'b1; gnt_en = 1'b1;
    redirect = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
    step(2);
    chk_cnt++;
    if ({mem_req, mem_addr, instr_valid, instr, instr_pc} !== {1'b0, 16'h0, 1'b0, 16'h0, 16'h0})
      $display("FAIL reset_outputs: got req=%b addr=%h v=%b instr=%h pc=%h want 0/0000/0/0000/0000",
               mem_req, mem_addr, instr_valid, instr, instr_pc);
    else pass_cnt++;
  endtask

  task automatic test_stream;
    do_reset(1'b1, 1'b1);
    step(1);
    chk_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0000})
      $display("FAIL stream_edge1_req: got %b/%h want 1/0000", mem_req, mem_addr);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if (instr_valid !== 1'b0) $display("FAIL stream_edge2_valid: got %b want 0", instr_valid);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0000, 16'h1000})
      $display("FAIL stream_first: got v=%b pc=%h instr=%h want 1/0000/1000", instr_valid, instr_pc, instr);
    else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      chk_cnt++;
      if (instr_valid !== 1'b0) $display("FAIL stream_gap%0d: got v=%b want 0", k, instr_valid);
      else pass_cnt++;
      step(1);
      chk_cnt++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, 16'(k), 16'(16'h1000 + k)})
        $display("FAIL stream_pc%0d: got v=%b pc=%h instr=%h want 1/%h/%h",
                 k, instr_valid, instr_pc, instr, 16'(k), 16'(16'h1000 + k));
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure;
    do_reset(1'b0, 1'b1);
    step(20);
    chk_cnt++;
    if ({instr_valid, instr_pc, mem_req} !== {1'b1, 16'h0000, 1'b0})
      $display("FAIL bp_full: got v=%b pc=%h req=%b want 1/0000/0", instr_valid, instr_pc, mem_req);
    else pass_cnt++;
    ready = 1'b1;
    step(1);
    chk_cnt++;
    if ({instr_valid, instr_pc} !== {1'b1, 16'h0001})
      $display("FAIL bp_pop1: got v=%b pc=%h want 1/0001", instr_valid, instr_pc);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if ({instr_valid, instr_pc, mem_req, mem_addr} !== {1'b1, 16'h0002, 1'b1, 16'h0004})
      $display("FAIL bp_pop2_resume: got v=%b pc=%h req=%b addr=%h want 1/0002/1/0004",
               instr_valid, instr_pc, mem_req, mem_addr);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if ({instr_valid, instr_pc} !== {1'b1, 16'h0003})
      $display("FAIL bp_pop3: got v=%b pc=%h want 1/0003", instr_valid, instr_pc);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0004, 16'h1004})
      $display("FAIL bp_pc4: got v=%b pc=%h instr=%h want 1/0004/1004", instr_valid, instr_pc, instr);
    else pass_cnt++;
  endtask

  task automatic test_redirect_gnt;
    do_reset(1'b1, 1'b1);
    step(11);
    chk_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0005})
      $display("FAIL rdg_req5: got %b/%h want 1/0005", mem_req, mem_addr);
    else pass_cnt++;
    redirect = 1'b1; redirect_pc = 16'h0040;
    step(1);
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_cnt++;
      if (instr_valid !== 1'b0) $display("FAIL rdg_drop%0d: got v=%b pc=%h want v=0", k, instr_valid, instr_pc);
      else pass_cnt++;
      if (k == 2) begin
        chk_cnt++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0040})
          $display("FAIL rdg_refetch: got %b/%h want 1/0040", mem_req, mem_addr);
        else pass_cnt++;
      end
      step(1);
    end
    chk_cnt++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0040, 16'h1040})
      $display("FAIL rdg_target: got v=%b pc=%h instr=%h want 1/0040/1040", instr_valid, instr_pc, instr);
    else pass_cnt++;
  endtask

  task automatic test_redirect_wait;
    do_reset(1'b0, 1'b1);
    step(6);
    chk_cnt++;
    if ({instr_valid, instr_pc, m_rv} !== {1'b1, 16'h0000, 1'b1})
      $display("FAIL rdw_setup: got v=%b pc=%h rvalid=%b want 1/0000/1", instr_valid, instr_pc, m_rv);
    else pass_cnt++;
    ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
    step(1);
    redirect = 1'b0;
    chk_cnt++;
    if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 16'h0100})
      $display("FAIL rdw_flush: got v=%b req=%b addr=%h want 0/1/0100", instr_valid, mem_req, mem_addr);
    else pass_cnt++;
    step(2);
    chk_cnt++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0100, 16'h1100})
      $display("FAIL rdw_target: got v=%b pc=%h instr=%h want 1/0100/1100", instr_valid, instr_pc, instr);
    else pass_cnt++;
  endtask

  task automatic test_halt;
    do_reset(1'b0, 1'b1);
    step(4);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    chk_cnt++;
    if ({instr_valid, instr_pc, mem_req} !== {1'b1, 16'h0000, 1'b0})
      $display("FAIL halt_enter: got v=%b pc=%h req=%b want 1/0000/0", instr_valid, instr_pc, mem_req);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk_cnt++;
      if (mem_req !== 1'b0) $display("FAIL halt_noreq%0d: got req=%b want 0", k, mem_req);
      else pass_cnt++;
    end
    ready = 1'b1;
    step(1);
    chk_cnt++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0001, 16'h1001})
      $display("FAIL halt_pending_pushed: got v=%b pc=%h instr=%h want 1/0001/1001", instr_valid, instr_pc, instr);
    else pass_cnt++;
    step(5);
    chk_cnt++;
    if ({instr_valid, mem_req} !== {1'b0, 1'b0})
      $display("FAIL halt_drained: got v=%b req=%b want 0/0", instr_valid, mem_req);
    else pass_cnt++;
  endtask

  task automatic test_wrap_and_reset;
    do_reset(1'b0, 1'b0);
    step(1);
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step(1);
    redirect = 1'b0;
    chk_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 16'hFFFF})
      $display("FAIL wrap_req_ffff: got %b/%h want 1/FFFF", mem_req, mem_addr);
    else pass_cnt++;
    gnt_en = 1'b1;
    step(2);
    chk_cnt++;
    if ({instr_valid, instr_pc, instr, mem_req, mem_addr} !== {1'b1, 16'hFFFF, 16'h0FFF, 1'b1, 16'h0000})
      $display("FAIL wrap_next: got v=%b pc=%h instr=%h req=%b addr=%h want 1/FFFF/0FFF/1/0000",
               instr_valid, instr_pc, instr, mem_req, mem_addr);
    else pass_cnt++;
    step(1);
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({mem_req, mem_addr, instr_valid, instr, instr_pc} !== {1'b0, 16'h0, 1'b0, 16'h0, 16'h0})
      $display("FAIL async_reset: got req=%b addr=%h v=%b instr=%h pc=%h want 0/0000/0/0000/0000",
               mem_req, mem_addr, instr_valid, instr, instr_pc);
    else pass_cnt++;
    #2;
    rst = 1'b0;
    chk_cnt++;
    if (m_rv !== 1'b1) $display("FAIL late_rvalid_setup: got rvalid=%b want 1", m_rv);
    else pass_cnt++;
    step(1);
    chk_cnt++;
    if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 16'h0000})
      $display("FAIL late_rvalid_ignored: got v=%b req=%b addr=%h want 0/1/0000", instr_valid, mem_req, mem_addr);
    else pass_cnt++;
    step(2);
    chk_cnt++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0000, 16'h1000})
      $display("FAIL post_reset_fetch: got v=%b pc=%h instr=%h want 1/0000/1000", instr_valid, instr_pc, instr);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_gnt;
    test_redirect_wait;
    test_halt;
    test_wrap_and_reset;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/lc3_fetch.md
Name: lc3_fetch

Overview:
Instruction fetch stage for the LC-3 core. It sits directly upstream of the decode/execute CPU block. It issues word reads to instruction memory over a request/grant/response handshake and buffers the returned words with their PCs in a small prefetch FIFO. It presents one instruction at a time to the CPU over a valid/ready handshake, and it supports branch redirect (flush) and halt.

Parameters:
ADDR_W, 16, instruction address width; the PC wraps modulo 2^ADDR_W.
DATA_W, 16, instruction word width.
FIFO_DEPTH, 4, prefetch entries; must be a power of 2 and at least 2.
RESET_PC, 0, first fetch address after reset.

Ports:
i_clk  input  1  clock; all state changes on its rising edge.
i_rst  input  1  asynchronous, active-high reset.
o_mem_req  output  1  read request to instruction memory.
o_mem_addr  output  ADDR_W  request address; meaningful only while o_mem_req is high.
i_mem_gnt  input  1  memory accepts the request this cycle (req & gnt = transfer).
i_mem_rvalid  input  1  read data valid; at least 1 cycle after the granting cycle.
i_mem_rdata  input  DATA_W  read data.
o_instr_valid  output  1  the FIFO head is valid.
o_instr  output  DATA_W  instruction word at the FIFO head.
o_instr_pc  output  ADDR_W  address of o_instr.
i_instr_ready  input  1  consumer accepts the head (valid & ready = pop).
i_redirect  input  1  branch taken: flush and refetch from i_redirect_pc.
i_redirect_pc  input  ADDR_W  redirect target.
i_halt  input  1  HALT seen; stop issuing new fetches.

Behaviour:
- Reset (async, while i_rst is high): state IDLE; fetch_pc = RESET_PC; FIFO empty. Outputs: o_mem_req=0, o_mem_addr=RESET_PC, o_instr_valid=0, o_instr=0, o_instr_pc=0. Reset mid-transaction abandons everything, and a late rvalid after reset is ignored (state IDLE).
- At most one memory request is outstanding. o_mem_addr = fetch_pc.
- States:
  - IDLE: o_mem_req=0. Go to REQ when FIFO count < FIFO_DEPTH and not halted.
  - REQ: o_mem_req=1. On gnt, latch req_pc = fetch_pc, set fetch_pc = fetch_pc+1 (wraps at all-ones to 0), go to WAIT. Address may change while not yet granted (redirect only).
  - WAIT: on rvalid, push {req_pc, rdata}. Then go to REQ if count after the push < FIFO_DEPTH and not halted; otherwise go to IDLE.
  - DRAIN: discard one response; on rvalid go to IDLE.
  - HALTED: o_mem_req=0 and no further fetches until reset. FIFO keeps draining to the consumer.
- Redirect (priority over all other events in the same cycle):
  - FIFO flushed (count=0) and fetch_pc = i_redirect_pc at the edge. A pop in the same cycle is legal and discarded.
  - In REQ without gnt: stay in REQ; the next request uses the new PC.
  - In REQ with gnt: the granted fetch is stale; go to DRAIN. fetch_pc = i_redirect_pc (not incremented).
  - In WAIT with rvalid: discard the data; go to REQ.
  - In WAIT without rvalid: go to DRAIN.
  - In IDLE or DRAIN: PC updated, state rules unchanged.
  - In HALTED: flush and update the PC, but remain HALTED.
- Halt: sampled every cycle and sticky until reset.
  - In IDLE or REQ without gnt: go to HALTED.
  - In REQ with gnt, or in WAIT: the outstanding response completes and is pushed, then go to HALTED.
- FIFO:
  - A push and a pop in the same cycle are allowed; count is unchanged.
  - A push is never attempted when full, because a request is issued only if count < FIFO_DEPTH.
  - A pop is ignored when empty.
  - o_instr and o_instr_pc come from registered FIFO storage. The head is stable while valid & !ready.
- Latency (zero-wait memory: gnt in the REQ cycle, rvalid the next cycle):
  - Edge1 after reset release: IDLE to REQ.
  - Edge2: grant.
  - Edge3: push; o_instr_valid=1 after edge3.
  - Steady-state throughput is 1 instruction per 2 cycles.
- Counters and pointers are modulo FIFO_DEPTH, with a count of width log2(FIFO_DEPTH)+1.

Test Plan:
1. Reset, RESET_PC=0, zero-wait memory returning mem[a]=a+16'h1000, consumer ready=1 -> first o_instr=16'h1000 with o_instr_pc=0 valid after the 3rd edge; then PCs 1, 2, 3 in order, each 2 cycles apart.
2. Consumer ready=0 for 20 cycles -> exactly 4 entries (PC 0–3) buffered and o_mem_req low. Then ready=1 -> PCs 0–3 delivered back-to-back and fetch resumes at PC 4.
3. Redirect to 16'h0040 in the same cycle as gnt of PC 5 -> the PC 5 response is discarded (DRAIN). The next delivered instruction has PC 16'h0040 and no PC 5 or older entry appears.
4. Redirect in WAIT with rvalid in the same cycle, plus a pop -> FIFO empty next cycle, data dropped, REQ to the redirect PC the cycle after.
5. i_halt asserted during WAIT -> the pending word is pushed, o_mem_req stays 0 forever, and the FIFO drains normally to empty.
6. Fetch from 16'hFFFF -> the next request address is 16'h0000; i_rst asserted during WAIT -> all outputs at reset values immediately and a late rvalid is ignored.
